alarm_timer: RTL and testbench

Programmable seconds-resolution countdown timer for the anti-theft alarm system. It owns the one-second tick generator, restarts it on every timer start, and holds four programmable interval values (arm delay, driver delay, passenger delay, alarm-on time). It emits a one-cycle `expired` pulse when the selected interval has elapsed. It sits between the alarm FSM, which issues `start_timer` with an interval index, and the user programming inputs.

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/sec_tick.sv | 33 +++
 rtl/alarm_timer.sv | 98 +++++++++
 tb/tb_alarm_timer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_pkg                                                                  |
// | Shared constants for the alarm system: interval indices, width, FSM codes. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alarm_pkg;

    localparam logic [1:0] IDX_ARM       = 2'd0;
    localparam logic [1:0] IDX_DRIVER    = 2'd1;
    localparam logic [1:0] IDX_PASSENGER = 2'd2;
    localparam logic [1:0] IDX_ALARM     = 2'd3;

    localparam int TIME_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_EXPIRE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sec_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sec_tick                                                                   |
// | One-second tick generator; sync restarts the second from the beginning.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sec_tick #(
    parameter int unsigned TICKS_PER_SEC = 27_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync,
    output logic tick
);

    localparam logic [31:0] c_RELOAD = 32'(TICKS_PER_SEC - 1);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= c_RELOAD;
        end else if (sync || tick) begin
            r_cnt <= c_RELOAD;
        end else begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign tick = (r_cnt == 32'd0);

endmodule
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_timer                                                                |
// | Programmable seconds countdown with four stored intervals and an expired   |
// | pulse. Define ALARM_TIMER_REMAINING_EN to expose the remaining-seconds port.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alarm_timer
    import alarm_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 27_000_000,
    parameter int T_ARM_DEF       = 6,
    parameter int T_DRIVER_DEF    = 8,
    parameter int T_PASSENGER_DEF = 15,
    parameter int T_ALARM_DEF     = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_timer,
    input  logic [1:0]        interval_sel,
    input  logic              prog_we,
    input  logic [1:0]        prog_sel,
    input  logic [TIME_W-1:0] prog_val,
    output logic              busy,
    output logic              expired
`ifdef ALARM_TIMER_REMAINING_EN
    ,
    output logic [TIME_W-1:0] remaining
`endif
);

    logic              w_tick;
    logic [TIME_W-1:0] w_load;
    logic [TIME_W-1:0] r_interval [0:3];
    logic [1:0]        r_state;
    logic [TIME_W-1:0] r_count;

    sec_tick #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .sync    (start_timer),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_interval[IDX_ARM]       <= TIME_W'(T_ARM_DEF);
            r_interval[IDX_DRIVER]    <= TIME_W'(T_DRIVER_DEF);
            r_interval[IDX_PASSENGER] <= TIME_W'(T_PASSENGER_DEF);
            r_interval[IDX_ALARM]     <= TIME_W'(T_ALARM_DEF);
        end else if (prog_we) begin
            r_interval[prog_sel] <= prog_val;
        end
    end

    // Read before the same-edge program write lands, so a start sees the old value.
    assign w_load = r_interval[interval_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_COUNT: begin
                    if (start_timer) begin
                        r_count <= w_load;
                        r_state <= (w_load == '0) ? ST_EXPIRE : ST_COUNT;
                    end else if (w_tick) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == TIME_W'(1)) begin
                            r_state <= ST_EXPIRE;
                        end
                    end
                end
                default: begin
                    if (start_timer) begin
                        r_count <= w_load;
                        r_state <= (w_load == '0) ? ST_EXPIRE : ST_COUNT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (r_state == ST_COUNT);
    assign expired = (r_state == ST_EXPIRE);

`ifdef ALARM_TIMER_REMAINING_EN
    assign remaining = (r_state == ST_COUNT) ? r_count : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alarm_timer                                                             |
// | Self-checking bench; expected outputs come from a start-time/deadline model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alarm_timer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval_sel = 2'd0;
    logic       prog_we = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic [3:0] prog_val = 4'd0;
    logic       busy;
    logic       expired;
`ifdef ALARM_TIMER_REMAINING_EN
    logic [3:0] remaining;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a countdown is just its start cycle and its loaded seconds.
    int m_iv [4];
    bit m_active;
    int m_start;
    int m_n;

    always #5 clk = ~clk;

    alarm_timer #(
        .TICKS_PER_SEC   (T),
        .T_ARM_DEF       (6),
        .T_DRIVER_DEF    (8),
        .T_PASSENGER_DEF (15),
        .T_ALARM_DEF     (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_timer  (start_timer),
        .interval_sel (interval_sel),
        .prog_we      (prog_we),
        .prog_sel     (prog_sel),
        .prog_val     (prog_val),
        .busy         (busy),
        .expired      (expired)
`ifdef ALARM_TIMER_REMAINING_EN
        ,
        .remaining    (remaining)
`endif
    );

    function automatic void model_reset();
        m_iv[0] = 6; m_iv[1] = 8; m_iv[2] = 15; m_iv[3] = 10;
        m_active = 1'b0;
        m_start = 0;
        m_n = 0;
    endfunction

    function automatic int exp_end();
        return m_start + ((m_n == 0) ? 1 : m_n * T + 1);
    endfunction

    function automatic logic exp_busy();
        return m_active && (cyc > m_start) && (cyc < exp_end());
    endfunction

    function automatic logic exp_expired();
        return m_active && (cyc == exp_end());
    endfunction

    function automatic int exp_rem();
        return exp_busy() ? (m_n - (cyc - m_start - 1) / T) : 0;
    endfunction

    // Called at a falling edge: applies inputs for the current cycle, returns at the next falling edge.
    task automatic drive(input logic st, input logic [1:0] sel, input logic we,
                         input logic [1:0] ps, input logic [3:0] pv);
        int ld;
        start_timer  = st;
        interval_sel = sel;
        prog_we      = we;
        prog_sel     = ps;
        prog_val     = pv;
        ld = m_iv[sel];
        if (we) m_iv[ps] = int'(pv);
        if (st) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_n      = ld;
        end
        @(posedge clk);
        #1;
        start_timer = 1'b0;
        prog_we     = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_assert++;
        if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired got=%b exp=0", expired); end
`ifdef ALARM_TIMER_REMAINING_EN
        n_assert++;
        if (remaining !== 4'd0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        drive(1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic test_default_arm();
        for (int i = 0; i < 30; i++) begin
            drive(i == 0, 2'd0, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL arm_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL arm_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
    endtask

    task automatic test_program();
        logic [1:0] idx;
        logic [3:0] val;
        drive(1'b0, 2'd0, 1'b1, 2'd2, 4'd3);
        for (int i = 0; i < 16; i++) begin
            drive(i == 0, 2'd2, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL prog_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL prog_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
        for (int i = 0; i < 36; i++) begin
            drive(i == 0, 2'd1, i == 0, 2'd1, 4'd2);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL samecyc_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL samecyc_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
        idx = 2'($urandom_range(0, 3));
        val = 4'($urandom_range(1, 5));
        drive(1'b0, 2'd0, 1'b1, idx, val);
        for (int i = 0; i < 24; i++) begin
            drive(i == 0, idx, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL rndprog_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL rndprog_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
    endtask

    task automatic test_zero();
        drive(1'b0, 2'd0, 1'b1, 2'd3, 4'd0);
        for (int i = 0; i < 5; i++) begin
            drive(i == 0, 2'd3, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL zero_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL zero_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
    endtask

    task automatic test_restart();
        drive(1'b0, 2'd0, 1'b1, 2'd0, 4'd6);
        drive(1'b0, 2'd0, 1'b1, 2'd1, 4'd8);
        for (int i = 0; i < 48; i++) begin
            drive((i == 0) || (i == 10), (i == 10) ? 2'd1 : 2'd0, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL restart_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL restart_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 9; i++) begin
            drive(i == 0, 2'd0, 1'b0, 2'd0, 4'd0);
        end
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        n_assert++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_assert++;
        if (expired !== 1'b0) begin n_fail++; $display("FAIL abort_expired got=%b exp=0", expired); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc++;
        for (int i = 0; i < 95; i++) begin
            drive(i == 30, 2'd2, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL abort_busy2 cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL abort_expired2 cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
        end
    endtask

    task automatic test_remaining();
        for (int i = 0; i < 64; i++) begin
            drive(i == 0, 2'd2, 1'b0, 2'd0, 4'd0);
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL rem_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
`ifdef ALARM_TIMER_REMAINING_EN
            n_assert++;
            if (remaining !== 4'(exp_rem())) begin n_fail++; $display("FAIL rem_value cyc=%0d got=%0d exp=%0d", cyc, remaining, exp_rem()); end
`endif
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            drive(r == 0, 2'($urandom_range(0, 3)), (r == 1) || (r == 2),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            n_assert++;
            if (busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy()); end
            n_assert++;
            if (expired !== exp_expired()) begin n_fail++; $display("FAIL rand_expired cyc=%0d got=%b exp=%b", cyc, expired, exp_expired()); end
`ifdef ALARM_TIMER_REMAINING_EN
            n_assert++;
            if (remaining !== 4'(exp_rem())) begin n_fail++; $display("FAIL rand_remaining cyc=%0d got=%0d exp=%0d", cyc, remaining, exp_rem()); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_default_arm();
        test_program();
        test_zero();
        test_restart();
        test_reset_abort();
        test_remaining();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
